// File: rtl/mtl_timing_pkg.sv
// Shared raster geometry for the 800x480 MTL panel timing path.
// Default porch/sync widths, coordinate widths and coordinate types.
package mtl_timing_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 210;
    localparam int DEF_H_SYNC   = 30;
    localparam int DEF_H_BACK   = 16;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 22;
    localparam int DEF_V_SYNC   = 13;
    localparam int DEF_V_BACK   = 10;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_PIPE_DLY = 2;

    typedef logic [X_W-1:0] xpos_t;
    typedef logic [Y_W-1:0] ypos_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that realigns sync/de with downstream pipelines.
// DEPTH=0 degenerates to a plain wire.
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout_o = din_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
                end else begin
                    stage_q[0] <= din_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign dout_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mtl_scan_timing.sv
// Free-running raster scan counters with line/frame strobes, plus panel
// sync and data-enable delayed to match the downstream colour pipeline.
module mtl_scan_timing
    import mtl_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int PIPE_DLY = DEF_PIPE_DLY
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    output logic [X_W-1:0] Xpos,
    output logic [Y_W-1:0] Ypos,
    output logic           line_start,
    output logic           frame_start,
    output logic           hsync_n,
    output logic           vsync_n,
    output logic           de
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam xpos_t X_LAST   = xpos_t'(H_TOTAL - 1);
    localparam ypos_t Y_LAST   = ypos_t'(V_TOTAL - 1);
    localparam xpos_t HS_FIRST = xpos_t'(H_ACTIVE + H_FRONT);
    localparam xpos_t HS_LAST  = xpos_t'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam ypos_t VS_FIRST = ypos_t'(V_ACTIVE + V_FRONT);
    localparam ypos_t VS_LAST  = ypos_t'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam xpos_t X_VIS    = xpos_t'(H_ACTIVE);
    localparam ypos_t Y_VIS    = ypos_t'(V_ACTIVE);

    xpos_t xpos_q, xpos_d;
    ypos_t ypos_q, ypos_d;
    logic  line_start_q, line_start_d;
    logic  frame_start_q, frame_start_d;
    logic  x_wrap, y_wrap;
    logic  hs_raw_n, vs_raw_n, de_raw;

    always_comb begin
        x_wrap        = (xpos_q == X_LAST);
        y_wrap        = (ypos_q == Y_LAST);
        xpos_d        = xpos_q;
        ypos_d        = ypos_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (en) begin
            xpos_d = x_wrap ? '0 : xpos_q + xpos_t'(1);
            if (x_wrap) begin
                ypos_d = y_wrap ? '0 : ypos_q + ypos_t'(1);
            end
            // Strobes describe the value the counters are about to take
            line_start_d  = x_wrap;
            frame_start_d = x_wrap && y_wrap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xpos_q        <= '0;
            ypos_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hs_raw_n = !((xpos_q >= HS_FIRST) && (xpos_q <= HS_LAST));
    assign vs_raw_n = !((ypos_q >= VS_FIRST) && (ypos_q <= VS_LAST));
    assign de_raw   = (xpos_q < X_VIS) && (ypos_q < Y_VIS);

    // Delay runs every clock regardless of en, flushing to sync-high/de-low
    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (3'b110)
    ) u_sync_dly (
        .clk    (clk),
        .rst    (reset),
        .din_i  ({hs_raw_n, vs_raw_n, de_raw}),
        .dout_o ({hsync_n, vsync_n, de})
    );

    assign Xpos        = xpos_q;
    assign Ypos        = ypos_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
